// File: rtl/xor_key_scheduler.sv
// Round-robin shared keyed-XOR datapath with key load/lock/zeroize.
// The key register never reaches an output port.
module xor_key_scheduler #(
  parameter int DW      = 128,
  parameter int NUM_REQ = 2,
  parameter int IDW     = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_REQ-1:0]    req_valid,
  input  logic [NUM_REQ*DW-1:0] req_data,
  output logic [NUM_REQ-1:0]    req_ready,
  input  logic                  key_load,
  input  logic [DW-1:0]         key_in,
  input  logic                  key_lock,
  input  logic                  zeroize,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DW-1:0]         out_data,
  output logic [IDW-1:0]        out_id,
  output logic                  key_valid,
  output logic                  key_locked,
  output logic                  err
);

  typedef enum logic {NOKEY, KEYED} state_t;

  state_t         state;
  state_t         state_nx;
  logic [DW-1:0]  key;
  logic           lock;
  logic [IDW-1:0] rr_ptr;
  logic [IDW-1:0] rr_nx;

  logic           keyed;
  logic           load_ok;
  logic           load_err;
  logic           lock_err;
  logic           req_err;
  logic           grant_en;
  logic           found;
  logic           hs;
  logic [IDW-1:0] sel_id;
  logic [DW-1:0]  sel_data;

  assign keyed      = (state == KEYED);
  assign key_valid  = keyed;
  assign key_locked = lock;

  // A reload must never race a pending result, so a locked key
  // or an occupied output slot refuses it.
  assign load_ok  = key_load && !zeroize &&
                    (!keyed || (!lock && !out_valid));
  assign load_err = key_load && !zeroize && !load_ok;
  assign lock_err = key_lock && !zeroize && !keyed;
  assign req_err  = !keyed && (|req_valid);

  assign grant_en = keyed && !zeroize && !load_ok &&
                    (!out_valid || out_ready);
  assign hs       = grant_en && found;

  // Round-robin scan: first valid at or above rr_ptr, else wrap.
  always_comb begin
    found    = 1'b0;
    sel_id   = '0;
    sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && req_valid[i] && i >= int'(rr_ptr)) begin
        found    = 1'b1;
        sel_id   = IDW'(i);
        sel_data = req_data[i*DW +: DW];
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && req_valid[i] && i < int'(rr_ptr)) begin
        found    = 1'b1;
        sel_id   = IDW'(i);
        sel_data = req_data[i*DW +: DW];
      end
    end
  end

  // Grant decode and pointer advance past the winner.
  always_comb begin
    req_ready = '0;
    rr_nx     = rr_ptr;
    if (hs) begin
      req_ready = NUM_REQ'(1) << sel_id;
      if (int'(sel_id) == NUM_REQ - 1)
        rr_nx = '0;
      else
        rr_nx = sel_id + IDW'(1);
    end
  end

  // Key lifecycle next state.
  always_comb begin
    state_nx = state;
    unique case (state)
      NOKEY: if (load_ok) state_nx = KEYED;
      KEYED: if (zeroize) state_nx = NOKEY;
      default: state_nx = NOKEY;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= NOKEY;
    else        state <= state_nx;
  end

  // Key, lock flag and arbitration pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key    <= '0;
      lock   <= 1'b0;
      rr_ptr <= '0;
    end else begin
      rr_ptr <= rr_nx;
      if (zeroize) begin
        key  <= '0;
        lock <= 1'b0;
      end else begin
        if (load_ok)           key  <= key_in;
        if (key_lock && keyed) lock <= 1'b1;
      end
    end
  end

  // Output slot: load on handshake, clear on drain or zeroize.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_id    <= '0;
    end else if (zeroize) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_id    <= '0;
    end else if (hs) begin
      out_valid <= 1'b1;
      out_data  <= sel_data ^ key;
      out_id    <= sel_id;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // Error pulse for any refused operation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err <= 1'b0;
    else        err <= load_err | lock_err | req_err;
  end

endmodule

// File: tb/tb_xor_key_scheduler.sv
// Scoreboard bench for xor_key_scheduler.
// A round-robin/key model predicts grants and results.
module tb_xor_key_scheduler;

  localparam int DW = 128;
  localparam int NR = 2;
  localparam int IW = 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [NR-1:0] req_valid;
  logic [NR*DW-1:0] req_data;
  logic [NR-1:0] req_ready;
  logic          key_load;
  logic [DW-1:0] key_in;
  logic          key_lock;
  logic          zeroize;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [IW-1:0] out_id;
  logic          key_valid;
  logic          key_locked;
  logic          err;

  typedef struct {
    logic [DW-1:0] data;
    logic [IW-1:0] id;
  } exp_t;

  exp_t sb[$];
  exp_t e;

  int checks = 0;
  int errors = 0;
  int m_rr   = 0;
  logic [DW-1:0] m_key = '0;
  logic [DW-1:0] ones = '1;
  logic [NR-1:0] exp_rdy;
  int g;

  xor_key_scheduler #(.DW(DW), .NUM_REQ(NR), .IDW(IW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready),
    .key_load(key_load), .key_in(key_in),
    .key_lock(key_lock), .zeroize(zeroize),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_id(out_id),
    .key_valid(key_valid), .key_locked(key_locked),
    .err(err)
  );

  always #5 clk = ~clk;

  function automatic int rr_pick(input logic [NR-1:0] v,
                                 input int ptr);
    int idx;
    rr_pick = -1;
    for (int k = 0; k < NR; k++) begin
      idx = (ptr + k) % NR;
      if (rr_pick < 0 && v[idx]) rr_pick = idx;
    end
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req_valid = '0; req_data = '0;
    key_load = 1'b0; key_in = '0;
    key_lock = 1'b0; zeroize = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({out_valid, out_id, req_ready, key_valid,
         key_locked, err} !== '0) begin
      errors++;
      $display("FAIL reset_ctrl got=%b want=0",
        {out_valid, out_id, req_ready, key_valid,
         key_locked, err});
    end
    checks++;
    if (out_data !== '0) begin
      errors++;
      $display("FAIL reset_data got=%h want=0", out_data);
    end
    rst_n = 1'b1;
    m_rr = 0;
    next_cycle();
  endtask

  task automatic test_first_xfer();
    key_load = 1'b1;
    key_in = ones;
    next_cycle();
    key_load = 1'b0;
    m_key = ones;
    req_valid = 2'b01;
    req_data[0 +: DW] = 128'h0F;
    out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (key_valid !== 1'b1) begin
      errors++;
      $display("FAIL first_keyvalid got=%b want=1", key_valid);
    end
    g = rr_pick(req_valid, m_rr);
    exp_rdy = '0;
    if (g >= 0) exp_rdy[g] = 1'b1;
    checks++;
    if (req_ready !== exp_rdy) begin
      errors++;
      $display("FAIL first_ready got=%b want=%b",
        req_ready, exp_rdy);
    end
    e.data = req_data[g*DW +: DW] ^ m_key;
    e.id = IW'(g);
    sb.push_back(e);
    m_rr = (g + 1) % NR;
    next_cycle();
    req_valid = '0;
    @(negedge clk);
    e = sb.pop_front();
    checks++;
    if (out_valid !== 1'b1 || out_id !== e.id ||
        out_data !== {{120{1'b1}}, 8'hF0} ||
        out_data !== e.data) begin
      errors++;
      $display("FAIL first_out got=%b/%0d/%h want=1/%0d/%h",
        out_valid, out_id, out_data, e.id, e.data);
    end
    next_cycle();
  endtask

  task automatic test_round_robin();
    out_ready = 1'b1;
    req_valid = 2'b11;
    for (int c = 0; c < 4; c++) begin
      req_data = {$urandom, $urandom, $urandom, $urandom,
                  $urandom, $urandom, $urandom, $urandom};
      @(negedge clk);
      if (out_valid) begin
        e = sb.pop_front();
        checks++;
        if (out_id !== e.id || out_data !== e.data) begin
          errors++;
          $display("FAIL rr_out c=%0d got=%0d/%h want=%0d/%h",
            c, out_id, out_data, e.id, e.data);
        end
      end
      g = rr_pick(req_valid, m_rr);
      exp_rdy = '0;
      if (g >= 0) exp_rdy[g] = 1'b1;
      checks++;
      if (req_ready !== exp_rdy) begin
        errors++;
        $display("FAIL rr_ready c=%0d got=%b want=%b",
          c, req_ready, exp_rdy);
      end
      e.data = req_data[g*DW +: DW] ^ m_key;
      e.id = IW'(g);
      sb.push_back(e);
      m_rr = (g + 1) % NR;
      next_cycle();
    end
    req_valid = '0;
    @(negedge clk);
    e = sb.pop_front();
    checks++;
    if (out_valid !== 1'b1 || out_id !== e.id ||
        out_data !== e.data) begin
      errors++;
      $display("FAIL rr_last got=%b/%0d/%h want=1/%0d/%h",
        out_valid, out_id, out_data, e.id, e.data);
    end
    next_cycle();
  endtask

  task automatic test_stall();
    out_ready = 1'b1;
    req_valid = 2'b01;
    req_data = {128'hAAAA_5555, 128'h1357_9BDF};
    @(negedge clk);
    g = rr_pick(req_valid, m_rr);
    checks++;
    if (req_ready !== 2'b01) begin
      errors++;
      $display("FAIL stall_grant got=%b want=01", req_ready);
    end
    e.data = req_data[g*DW +: DW] ^ m_key;
    e.id = IW'(g);
    sb.push_back(e);
    m_rr = (g + 1) % NR;
    next_cycle();
    out_ready = 1'b0;
    req_valid = 2'b11;
    req_data = {128'hDEAD, 128'hBEEF};
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || req_ready !== 2'b00 ||
          out_id !== sb[0].id || out_data !== sb[0].data) begin
        errors++;
        $display("FAIL stall_hold c=%0d got=%b/%b/%0d/%h want=1/00/%0d/%h",
          c, out_valid, req_ready, out_id, out_data,
          sb[0].id, sb[0].data);
      end
      next_cycle();
    end
    out_ready = 1'b1;
    req_valid = '0;
    @(negedge clk);
    e = sb.pop_front();
    checks++;
    if (out_valid !== 1'b1 || out_data !== e.data) begin
      errors++;
      $display("FAIL stall_drain got=%b/%h want=1/%h",
        out_valid, out_data, e.data);
    end
    next_cycle();
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL stall_empty got=%b want=0", out_valid);
    end
    next_cycle();
  endtask

  task automatic test_lock();
    key_lock = 1'b1;
    next_cycle();
    key_lock = 1'b0;
    key_load = 1'b1;
    key_in = 128'h1234;
    @(negedge clk);
    checks++;
    if (key_locked !== 1'b1) begin
      errors++;
      $display("FAIL lock_flag got=%b want=1", key_locked);
    end
    next_cycle();
    key_load = 1'b0;
    @(negedge clk);
    checks++;
    if (err !== 1'b1) begin
      errors++;
      $display("FAIL lock_err got=%b want=1", err);
    end
    next_cycle();
    out_ready = 1'b1;
    req_valid = 2'b10;
    req_data = {128'h55, 128'h0};
    @(negedge clk);
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("FAIL lock_errpulse got=%b want=0", err);
    end
    g = rr_pick(req_valid, m_rr);
    exp_rdy = '0;
    if (g >= 0) exp_rdy[g] = 1'b1;
    checks++;
    if (req_ready !== exp_rdy) begin
      errors++;
      $display("FAIL lock_ready got=%b want=%b",
        req_ready, exp_rdy);
    end
    e.data = req_data[g*DW +: DW] ^ m_key;
    e.id = IW'(g);
    sb.push_back(e);
    m_rr = (g + 1) % NR;
    next_cycle();
    req_valid = '0;
    @(negedge clk);
    e = sb.pop_front();
    checks++;
    if (out_valid !== 1'b1 || out_id !== e.id ||
        out_data !== e.data) begin
      errors++;
      $display("FAIL lock_out got=%b/%0d/%h want=1/%0d/%h",
        out_valid, out_id, out_data, e.id, e.data);
    end
    next_cycle();
  endtask

  task automatic test_zeroize();
    out_ready = 1'b0;
    req_valid = 2'b01;
    req_data = {128'h0, 128'hC0FFEE};
    @(negedge clk);
    g = rr_pick(req_valid, m_rr);
    m_rr = (g + 1) % NR;
    next_cycle();
    req_valid = '0;
    zeroize = 1'b1;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1) begin
      errors++;
      $display("FAIL zero_pending got=%b want=1", out_valid);
    end
    next_cycle();
    zeroize = 1'b0;
    m_key = '0;
    sb.delete();
    @(negedge clk);
    checks++;
    if ({out_valid, key_valid, key_locked} !== 3'b000 ||
        out_data !== '0) begin
      errors++;
      $display("FAIL zero_clear got=%b/%h want=000/0",
        {out_valid, key_valid, key_locked}, out_data);
    end
    next_cycle();
    req_valid = 2'b01;
    @(negedge clk);
    checks++;
    if (req_ready !== 2'b00) begin
      errors++;
      $display("FAIL zero_ready got=%b want=00", req_ready);
    end
    next_cycle();
    req_valid = '0;
    @(negedge clk);
    checks++;
    if (err !== 1'b1) begin
      errors++;
      $display("FAIL zero_reqerr got=%b want=1", err);
    end
    next_cycle();
  endtask

  task automatic test_async_reset();
    key_load = 1'b1;
    key_in = {64'hA5A5_A5A5_A5A5_A5A5, 64'h0123_4567_89AB_CDEF};
    next_cycle();
    key_load = 1'b0;
    m_key = key_in;
    out_ready = 1'b0;
    req_valid = 2'b10;
    req_data = {128'h77, 128'h0};
    @(negedge clk);
    checks++;
    if (req_ready !== 2'b10) begin
      errors++;
      $display("FAIL ar_grant got=%b want=10", req_ready);
    end
    next_cycle();
    req_valid = '0;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || out_id !== 1'b1 ||
        out_data !== (128'h77 ^ m_key)) begin
      errors++;
      $display("FAIL ar_pending got=%b/%0d/%h want=1/1/%h",
        out_valid, out_id, out_data, 128'h77 ^ m_key);
    end
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({out_valid, out_id, req_ready, key_valid,
         key_locked, err} !== '0 || out_data !== '0) begin
      errors++;
      $display("FAIL ar_clear got=%b/%h want=0/0",
        {out_valid, out_id, req_ready, key_valid,
         key_locked, err}, out_data);
    end
    sb.delete();
    m_rr = 0;
    m_key = '0;
    @(negedge clk);
    rst_n = 1'b1;
    next_cycle();
  endtask

  initial begin
    test_reset();
    test_first_xfer();
    test_round_robin();
    test_stall();
    test_lock();
    test_zeroize();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
